// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared encodings and helpers for the request/ack memory bus
package bus_pkg;

    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } resp_state_e;

    function automatic logic size_supported(input logic [2:0] size);
        return (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W) ||
               (size == SIZE_BU) || (size == SIZE_HU);
    endfunction

    // Unsupported encodings are judged as words, matching how they are executed.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_B, SIZE_BU: return 1'b0;
            SIZE_H, SIZE_HU: return addr_lo[0];
            default:         return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/bus_lane_align.sv
// rtl/bus_lane_align.sv - byte-lane strobes, write replication and read extraction/extension
module bus_lane_align
    import bus_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wr_data_i,
    input  logic [31:0] ram_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wr_word_o,
    output logic [31:0] rd_data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Replicating the narrow data across lanes lets the strobe alone pick the target lane.
    always_comb begin
        be_o      = 4'b0000;
        wr_word_o = 32'h0;
        rd_data_o = 32'h0;
        byte_v    = ram_word_i[{addr_lo_i, 3'b000} +: 8];
        half_v    = addr_lo_i[1] ? ram_word_i[31:16] : ram_word_i[15:0];
        case (size_i)
            SIZE_B, SIZE_BU: begin
                be_o      = 4'b0001 << addr_lo_i;
                wr_word_o = {4{wr_data_i[7:0]}};
                rd_data_o = (size_i == SIZE_B) ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
            end
            SIZE_H, SIZE_HU: begin
                be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wr_word_o = {2{wr_data_i[15:0]}};
                rd_data_o = (size_i == SIZE_H) ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
            end
            default: begin
                be_o      = 4'b1111;
                wr_word_o = wr_data_i;
                rd_data_o = ram_word_i;
            end
        endcase
    end

endmodule

// File: rtl/bus_ram_responder.sv
// rtl/bus_ram_responder.sv - bus target with wait-state FSM and word RAM; optional BUS_RESP_ERR_EN error output
module bus_ram_responder
    import bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_en,
    input  logic        i_wr_rd,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_size,
`ifdef BUS_RESP_ERR_EN
    output logic        o_err,
`endif
    output logic        o_ack,
    output logic [31:0] o_rd_data
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

    resp_state_e   state_q;
    logic [3:0]    cnt_q;
    logic [AW+1:0] addr_q;
    logic [2:0]    size_q;
    logic          wr_rd_q;
    logic [31:0]   wr_data_q;
    logic          ack_q;
    logic [31:0]   rd_data_q;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          unused_addr_hi;
    logic          use_live;
    logic [AW+1:0] acc_addr;
    logic [2:0]    acc_size;
    logic          acc_wr;
    logic [31:0]   acc_wr_data;
    logic [AW-1:0] acc_idx;
    logic          acc_err;
    logic          access_edge;
    logic          mem_we;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wr_word;
    logic [31:0]   lane_rd;
    logic [31:0]   ack_rd_d;

    assign unused_addr_hi = ^i_addr[31:AW+2];

    // With LATENCY=0 the access edge is the capture edge, so the live bus feeds the RAM path.
    assign use_live    = (state_q == ST_IDLE);
    assign acc_addr    = use_live ? i_addr[AW+1:0] : addr_q;
    assign acc_size    = use_live ? i_size : size_q;
    assign acc_wr      = use_live ? i_wr_rd : wr_rd_q;
    assign acc_wr_data = use_live ? i_wr_data : wr_data_q;
    assign acc_idx     = acc_addr[AW+1:2];

    assign access_edge = ((state_q == ST_IDLE) && i_bus_en && (LATENCY == 0)) ||
                         ((state_q == ST_WAIT) && (cnt_q == 4'd1));

`ifdef BUS_RESP_ERR_EN
    assign acc_err = is_misaligned(acc_size, acc_addr[1:0]) || !size_supported(acc_size);
`else
    assign acc_err = 1'b0;
`endif

    bus_lane_align u_lane_align (
        .size_i     (acc_size),
        .addr_lo_i  (acc_addr[1:0]),
        .wr_data_i  (acc_wr_data),
        .ram_word_i (mem_q[acc_idx]),
        .be_o       (lane_be),
        .wr_word_o  (lane_wr_word),
        .rd_data_o  (lane_rd)
    );

    assign mem_we   = access_edge && (acc_wr == WR) && !acc_err && !i_rst;
    assign ack_rd_d = ((acc_wr == WR) || acc_err) ? 32'h0 : lane_rd;

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_be[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= lane_wr_word[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            size_q    <= SIZE_W;
            wr_rd_q   <= RD;
            wr_data_q <= 32'h0;
            ack_q     <= 1'b0;
            rd_data_q <= 32'h0;
`ifdef BUS_RESP_ERR_EN
            o_err     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_bus_en) begin
                        addr_q    <= i_addr[AW+1:0];
                        size_q    <= i_size;
                        wr_rd_q   <= i_wr_rd;
                        wr_data_q <= i_wr_data;
                        cnt_q     <= LAT_LOAD;
                        if (access_edge) begin
                            state_q   <= ST_ACK;
                            ack_q     <= 1'b1;
                            rd_data_q <= ack_rd_d;
`ifdef BUS_RESP_ERR_EN
                            o_err     <= acc_err;
`endif
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (access_edge) begin
                        state_q   <= ST_ACK;
                        ack_q     <= 1'b1;
                        rd_data_q <= ack_rd_d;
`ifdef BUS_RESP_ERR_EN
                        o_err     <= acc_err;
`endif
                    end
                end
                ST_ACK: begin
                    state_q   <= ST_IDLE;
                    ack_q     <= 1'b0;
                    rd_data_q <= 32'h0;
`ifdef BUS_RESP_ERR_EN
                    o_err     <= 1'b0;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_ack     = ack_q;
    assign o_rd_data = rd_data_q;

endmodule
